// File: rtl/alu_muldiv_ctrl.sv
// EX-stage ALU control decoder with an iterative shift-add multiply / restoring divide engine and HI/LO.
// Optional feature macro ALU_SIGNED_MULDIV_EN: signed mult/div plus multu/divu.

module alu_muldiv_ctrl #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        ALU_op,
  input  logic [5:0]        inst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [OP_W-1:0]   op,
  output logic              illegal,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_ANDX = 6'b001100;
  localparam logic [5:0] F_ORX  = 6'b001101;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;
`ifdef ALU_SIGNED_MULDIV_EN
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              div_q, div_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [DATA_W-1:0] opb_q, opb_d, work_hi_q, work_hi_d, work_lo_q, work_lo_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [3:0] op4;
  logic       md_req, md_div, md_signed, start;

  always_comb begin
    op4       = 4'b0010;
    illegal   = 1'b0;
    md_req    = 1'b0;
    md_div    = 1'b0;
    md_signed = 1'b0;
    case (ALU_op)
      2'b01: op4 = 4'b0110;
      2'b10: begin
        case (inst)
          F_ADD:  op4 = 4'b0010;
          F_SUB:  op4 = 4'b0110;
          F_AND:  op4 = 4'b0000;
          F_OR:   op4 = 4'b0001;
          F_SLT:  op4 = 4'b0111;
          F_ANDX: op4 = 4'b0000;
          F_ORX:  op4 = 4'b0001;
          F_MULT, F_DIV: begin
            md_req = 1'b1;
            md_div = inst[1];
`ifdef ALU_SIGNED_MULDIV_EN
            md_signed = 1'b1;
`endif
          end
`ifdef ALU_SIGNED_MULDIV_EN
          F_MULTU, F_DIVU: begin
            md_req = 1'b1;
            md_div = inst[1];
          end
`endif
          default: illegal = 1'b1;
        endcase
      end
      default: op4 = 4'b0010;
    endcase
  end

  assign op    = OP_W'(op4);
  assign start = valid_in & md_req & (state_q == S_IDLE);

  // Engine works on magnitudes; the sign is re-applied when HI/LO are written.
  logic a_neg, b_neg;
  assign a_neg = md_signed & a[DATA_W-1];
  assign b_neg = md_signed & b[DATA_W-1];

  // Shift-add multiply step: {work_hi, work_lo} holds partial product over remaining multiplier bits.
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W-1:0] mul_hi_n, mul_lo_n;
  assign mul_sum  = {1'b0, work_hi_q} + {1'b0, (work_lo_q[0] ? opb_q : '0)};
  assign mul_hi_n = mul_sum[DATA_W:1];
  assign mul_lo_n = {mul_sum[0], work_lo_q[DATA_W-1:1]};

  // Restoring divide step: work_hi is the partial remainder, work_lo shifts dividend out and quotient in.
  logic [DATA_W:0]   div_rem_ext;
  logic              div_ok;
  logic [DATA_W-1:0] div_sub, div_hi_n, div_lo_n;
  assign div_rem_ext = {work_hi_q, work_lo_q[DATA_W-1]};
  assign div_ok      = div_rem_ext >= {1'b0, opb_q};
  assign div_sub     = DATA_W'(div_rem_ext - {1'b0, opb_q});
  assign div_hi_n    = div_ok ? div_sub : div_rem_ext[DATA_W-1:0];
  assign div_lo_n    = {work_lo_q[DATA_W-2:0], div_ok};

  logic [DATA_W-1:0]   step_hi, step_lo, quot_fix, rem_fix;
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic                res_neg;
  assign step_hi  = div_q ? div_hi_n : mul_hi_n;
  assign step_lo  = div_q ? div_lo_n : mul_lo_n;
  assign res_neg  = neg_a_q ^ neg_b_q;
  assign prod     = {step_hi, step_lo};
  assign prod_fix = res_neg ? -prod : prod;
  // A zero divisor keeps the all-ones quotient regardless of the dividend sign.
  assign quot_fix = (res_neg && (opb_q != '0)) ? -step_lo : step_lo;
  assign rem_fix  = neg_a_q ? -step_hi : step_hi;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    opb_d     = opb_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          div_d     = md_div;
          neg_a_d   = a_neg;
          neg_b_d   = b_neg;
          opb_d     = b_neg ? -b : b;
          work_hi_d = '0;
          work_lo_d = a_neg ? -a : a;
        end
      end
      S_RUN: begin
        cnt_d     = cnt_q + 1'b1;
        work_hi_d = step_hi;
        work_lo_d = step_lo;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          if (div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      opb_q     <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      opb_q     <= opb_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign stall = start | (state_q == S_RUN);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Self-checking bench for alu_muldiv_ctrl: decode table, directed multi-cycle sequences, random mult/div vs. arithmetic model.
// Honours ALU_SIGNED_MULDIV_EN the same way the design does.

module tb_alu_muldiv_ctrl;
  localparam int W = 32;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   ALU_op;
  logic [5:0]   inst;
  logic         valid_in;
  logic [W-1:0] a, b;
  logic [3:0]   op;
  logic         illegal, stall, busy, done;
  logic [W-1:0] hi, lo;

  alu_muldiv_ctrl #(.DATA_W(W), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ALU_op(ALU_op), .inst(inst), .valid_in(valid_in),
    .a(a), .b(b), .op(op), .illegal(illegal), .stall(stall), .busy(busy),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    bit              sgn;
    logic [63:0]     r;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = {32'h0, x};
    uy  = {32'h0, y};
    sgn = 1'b0;
`ifdef ALU_SIGNED_MULDIV_EN
    sgn = (f == F_MULT) || (f == F_DIV);
`endif
    if (f == F_MULT || f == F_MULTU) r = sgn ? 64'(sx * sy) : 64'(ux * uy);
    else if (y == '0)                r = {x, 32'hFFFF_FFFF};
    else if (sgn)                    r = {32'(sx % sy), 32'(sx / sy)};
    else                             r = {x % y, x / y};
    return r;
  endfunction

  // Called one step after the start edge; follows the operation to its DONE cycle.
  task automatic finish_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [63:0] exp, input bit hold,
                           input logic [W-1:0] nx, input logic [W-1:0] ny);
    int           lat, stall_n;
    bit           got_done, hilo_stable;
    logic [W-1:0] hi0, lo0;
    hi0 = hi;
    lo0 = lo;
    if (hold) begin
      a = nx;
      b = ny;
    end else begin
      valid_in = 1'b0;
      a = $urandom;
      b = $urandom;
    end
    lat = 0;
    stall_n = 1;
    got_done = 1'b0;
    hilo_stable = 1'b1;
    for (int i = 0; i < W + 10; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (stall) stall_n++;
      if (hi !== hi0 || lo !== lo0) hilo_stable = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({name, " done_seen"}, got_done, 1);
    check({name, " latency"}, lat, W);
    check({name, " stall_cycles"}, stall_n, W + 1);
    check({name, " hilo_held_in_run"}, hilo_stable, 1);
    check({name, " result"}, {hi, lo}, exp);
    check({name, " stall_in_done"}, stall, 0);
    check({name, " busy_in_done"}, busy, 1);
    $display("op %s a=%h b=%h -> hi=%h lo=%h lat=%0d", name, x, y, hi, lo, lat);
    if (!hold) begin
      @(posedge clk); #1;
      check({name, " done_single_pulse"}, done, 0);
      check({name, " idle_after"}, busy, 0);
    end
  endtask

  task automatic run_op(input string name, input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [63:0] exp, input bit hold,
                        input logic [W-1:0] nx, input logic [W-1:0] ny);
    @(negedge clk);
    ALU_op = 2'b10;
    inst = f;
    a = x;
    b = y;
    valid_in = 1'b1;
    #1;
    check({name, " stall_at_issue"}, stall, 1);
    @(posedge clk); #1;
    finish_op(name, x, y, exp, hold, nx, ny);
  endtask

  typedef struct {
    logic [1:0] alu;
    logic [5:0] fn;
    logic       vin;
    logic [3:0] eop;
    logic       eill;
    logic       estall;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [5:0]   f;
    logic [W-1:0] x, y;
    int           dcnt;

    vecs[0]  = '{2'b00, 6'b100010, 1'b1, 4'b0010, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 6'b000000, 1'b0, 4'b0110, 1'b0, 1'b0};
    vecs[2]  = '{2'b11, 6'b011000, 1'b1, 4'b0010, 1'b0, 1'b0};
    vecs[3]  = '{2'b10, 6'b100000, 1'b0, 4'b0010, 1'b0, 1'b0};
    vecs[4]  = '{2'b10, 6'b100010, 1'b0, 4'b0110, 1'b0, 1'b0};
    vecs[5]  = '{2'b10, 6'b100100, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[6]  = '{2'b10, 6'b100101, 1'b0, 4'b0001, 1'b0, 1'b0};
    vecs[7]  = '{2'b10, 6'b101010, 1'b0, 4'b0111, 1'b0, 1'b0};
    vecs[8]  = '{2'b10, 6'b001100, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[9]  = '{2'b10, 6'b001101, 1'b0, 4'b0001, 1'b0, 1'b0};
    vecs[10] = '{2'b10, 6'b011000, 1'b1, 4'b0010, 1'b0, 1'b1};
    vecs[11] = '{2'b10, 6'b011010, 1'b1, 4'b0010, 1'b0, 1'b1};
    vecs[12] = '{2'b10, 6'b111111, 1'b1, 4'b0010, 1'b1, 1'b0};
`ifdef ALU_SIGNED_MULDIV_EN
    vecs[13] = '{2'b10, 6'b011001, 1'b1, 4'b0010, 1'b0, 1'b1};
    vecs[14] = '{2'b10, 6'b011011, 1'b0, 4'b0010, 1'b0, 1'b0};
`else
    vecs[13] = '{2'b10, 6'b011001, 1'b1, 4'b0010, 1'b1, 1'b0};
    vecs[14] = '{2'b10, 6'b011011, 1'b0, 4'b0010, 1'b1, 1'b0};
`endif

    rst_n = 1'b0;
    valid_in = 1'b0;
    ALU_op = 2'b00;
    inst = 6'b0;
    a = '0;
    b = '0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset busy", busy, 0);
    check("reset stall", stall, 0);
    check("reset done", done, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      ALU_op = vecs[i].alu;
      inst = vecs[i].fn;
      valid_in = vecs[i].vin;
      #1;
      check($sformatf("decode[%0d] op", i), op, vecs[i].eop);
      check($sformatf("decode[%0d] illegal", i), illegal, vecs[i].eill);
      check($sformatf("decode[%0d] stall", i), stall, vecs[i].estall);
      $display("decode %0d alu=%b funct=%b -> op=%b illegal=%b stall=%b", i, vecs[i].alu, vecs[i].fn, op, illegal, stall);
      valid_in = 1'b0;
    end
    check("decode no start", busy, 0);

`ifdef ALU_SIGNED_MULDIV_EN
    run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'h2, 64'h0000_0001_FFFF_FFFE, 1'b0, '0, '0);
    run_op("mult_signed", F_MULT, -32'sd6, 32'd4, 64'hFFFF_FFFF_FFFF_FFE8, 1'b0, '0, '0);
    run_op("div_signed", F_DIV, -32'sd7, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, '0, '0);
`else
    run_op("mult_max", F_MULT, 32'hFFFF_FFFF, 32'h2, 64'h0000_0001_FFFF_FFFE, 1'b0, '0, '0);
`endif
    run_op("div_100_7", F_DIV, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, '0, '0);
    run_op("div_by_zero", F_DIV, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1'b0, '0, '0);

    // Reset mid-RUN with valid_in already dropped.
    @(negedge clk);
    ALU_op = 2'b10;
    inst = F_MULT;
    a = 32'h0F0F_0F0F;
    b = 32'h3;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_reset hi", hi, 0);
    check("midrun_reset lo", lo, 0);
    check("midrun_reset busy", busy, 0);
    check("midrun_reset stall", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    check("midrun_reset no_done", dcnt, 0);
    $display("midrun_reset hi=%h lo=%h busy=%b", hi, lo, busy);

    // Back-to-back with the request held the whole time.
    run_op("b2b_first", F_MULT, 32'h1234_5678, 32'h0000_9ABC, model(F_MULT, 32'h1234_5678, 32'h0000_9ABC),
           1'b1, 32'h0000_DEAD, 32'h0000_BEEF);
    @(posedge clk); #1;
    check("b2b idle busy", busy, 0);
    check("b2b idle stall", stall, 1);
    check("b2b idle done", done, 0);
    @(posedge clk); #1;
    check("b2b restarted", busy, 1);
    finish_op("b2b_second", 32'h0000_DEAD, 32'h0000_BEEF, model(F_MULT, 32'h0000_DEAD, 32'h0000_BEEF),
              1'b0, '0, '0);

    for (int i = 0; i < 16; i++) begin
`ifdef ALU_SIGNED_MULDIV_EN
      case ($urandom_range(0, 3))
        0: f = F_MULT;
        1: f = F_DIV;
        2: f = F_MULTU;
        default: f = F_DIVU;
      endcase
`else
      f = ($urandom_range(0, 1) == 0) ? F_MULT : F_DIV;
`endif
      x = $urandom;
      y = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) y = '0;
      run_op($sformatf("rand%0d", i), f, x, y, model(f, x, y), 1'b0, '0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_muldiv_ctrl.md
# alu_muldiv_ctrl

Parametrised successor to the processor's ALU control decoder. It decodes ALU_op and the R-type funct field into the ALU operation code every cycle, as before. It also owns an iterative multiply/divide engine with HI/LO result registers. While a mult/div runs, it raises a stall towards the pipeline. It sits in the EX stage between the main control unit and the ALU.

## Interface
- DATA_W, 32, operand and HI/LO width (even, ≥ 4)
- OP_W, 4, ALU operation code width (≥ 4; upper bits zero)
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- ALU_op  input  2  class from main control
- inst  input  6  funct field
- valid_in  input  1  instruction in EX is valid
- a  input  DATA_W  rs operand
- b  input  DATA_W  rt operand
- op  output  OP_W  ALU operation code, combinational
- illegal  output  1  ALU_op=10 with an unsupported funct
- stall  output  1  hold the pipeline
- busy  output  1  engine not idle
- done  output  1  one-cycle pulse when HI/LO update
- hi  output  DATA_W  HI register (product high half / remainder)
- lo  output  DATA_W  LO register (product low half / quotient)

## Operation
- Decode is combinational, with no latches; every path assigns op and illegal.
  - ALU_op 00 → 0010. ALU_op 01 → 0110. ALU_op 11 → 0010, illegal=0.
  - ALU_op 10, by funct: 100000 add → 0010; 100010 sub → 0110; 100100 and → 0000; 100101 or → 0001; 101010 slt → 0111; 001100 → 0000; 001101 → 0001.
  - funct 011000 mult, 011010 div → op 0010, illegal=0, start request.
  - Any other funct → op 0010, illegal=1, no other effect.
- start = valid_in & ALU_op==10 & funct∈{mult, div} & state==IDLE.
- FSM states:
  - IDLE: on start → RUN, latch a, b and kind, cnt=0.
  - RUN: one iteration per cycle, cnt+1. When cnt==DATA_W-1 → DONE.
  - DONE: unconditionally → IDLE.
- Multiply is shift-add; the result is 2·DATA_W bits: {hi, lo}. hi gets the upper half, lo the lower half.
- Divide is restoring: lo = quotient, hi = remainder.
- Divide by zero still takes full latency, then lo = all ones, hi = a.
- hi and lo change only at the edge entering DONE.
- stall = start | (state==RUN). stall is low in DONE, so the pipeline advances with hi/lo valid.
- busy = state≠IDLE. done = state==DONE.
- While busy, a new mult/div funct is not accepted. The pipeline is already stalled by this block.
- illegal and op remain live in every state.

## Timing
- Reset values: state IDLE, cnt 0, hi 0, lo 0, done 0, busy 0. stall is 0 unless start is high.
- Latency: start sampled at edge E0; RUN for DATA_W cycles (E1..E_DATA_W); DONE visible after E_DATA_W. Total DATA_W+1 cycles of busy; stall high for DATA_W+1 cycles (issue cycle plus RUN).
- Back-to-back: a second mult/div can start at the first edge after DONE, i.e. DATA_W+2 cycles after the first start.
- Reset asserted mid-RUN clears state and hi/lo immediately. The result is discarded and no done pulse is produced.
- valid_in dropping during RUN has no effect; the operation completes.

## Configuration
- ALU_SIGNED_MULDIV_EN defined:
  - 011000/011010 are signed mult/div. Operands are converted to magnitude and the result sign is corrected in DONE.
  - Remainder takes the dividend's sign.
  - 011001 multu and 011011 divu are added as unsigned starts.
  - Latency is unchanged.
- Not defined:
  - 011000/011010 are unsigned.
  - 011001/011011 decode as illegal.

## Test plan
- Reset then idle: rst_n low mid-cycle, then high → hi=lo=0, busy=0, stall=0. ALU_op=10, funct=100100 → op=0000, illegal=0. funct=111111 → illegal=1, op=0010.
- Unsigned multiply, DATA_W=32: a=0xFFFF_FFFF, b=0x0000_0002, funct 011000 → stall high 33 cycles. done pulses once; hi=0x0000_0001, lo=0xFFFF_FFFE.
- Divide: a=100, b=7, funct 011010 → lo=14, hi=2 after 33 cycles. Divide by zero, a=5 → lo=0xFFFF_FFFF, hi=5, same latency.
- Reset mid-RUN: start a multiply, pull rst_n low at cnt=10 → hi/lo=0, busy=0 asynchronously, no done pulse afterwards.
- Back-to-back with a retrigger attempt: hold mult funct and valid_in high throughout → second start exactly one cycle after DONE. Second result is correct; no start during RUN or DONE.
- With ALU_SIGNED_MULDIV_EN: a=-6, b=4, mult → hi=0xFFFF_FFFF, lo=0xFFFF_FFE8. div a=-7, b=2 → lo=-3, hi=-1. Without the macro: funct 011001 → illegal=1.
